// File: rtl/datmem_responder.sv
// Handshaked 32-byte big-endian data memory with a fixed number of wait states
// between request acceptance and the access edge.
module datmem_responder #(
  parameter int unsigned WAIT = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [4:0]  req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned AW    = 5;
  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 32;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             write_q;
  logic [AW-1:0]    addr_q;
  logic [DW-1:0]    wdata_q;
  logic             lat_en;
  logic             access;
  logic             misaligned;
  logic             mem_we;
  logic [2:0]       widx;
  logic [DW-1:0]    rdata_d;
  logic             err_d;

  logic [7:0] mem [DEPTH];

  assign widx       = addr_q[4:2];
  assign misaligned = (addr_q[1:0] != 2'b00);

  // Next state, access strobe and next response values
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lat_en  = 1'b0;
    access  = 1'b0;
    rdata_d = resp_rdata;
    err_d   = resp_err;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          lat_en  = 1'b1;
          cnt_d   = CNT_W'(WAIT);
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          access  = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (resp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    mem_we = access & write_q & ~misaligned;
    if (access) begin
      err_d   = misaligned;
      rdata_d = (write_q || misaligned) ? '0 :
                {mem[{widx, 2'd0}], mem[{widx, 2'd1}], mem[{widx, 2'd2}], mem[{widx, 2'd3}]};
    end
  end

  // State, latched request and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      write_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      req_ready  <= (state_d == ST_IDLE);
      resp_valid <= (state_d == ST_RESP);
      resp_rdata <= rdata_d;
      resp_err   <= err_d;
      if (lat_en) begin
        write_q <= req_write;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
    end
  end

  // Storage is not reset; writes happen only on an aligned store's access edge
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[{widx, 2'd0}] <= wdata_q[31:24];
      mem[{widx, 2'd1}] <= wdata_q[23:16];
      mem[{widx, 2'd2}] <= wdata_q[15:8];
      mem[{widx, 2'd3}] <= wdata_q[7:0];
    end
  end

endmodule

// File: tb/tb_datmem_responder.sv
// Self-checking bench for datmem_responder: directed plan plus random traffic
// against a byte-array reference model.
module tb_datmem_responder;

  localparam int unsigned WAIT_MAIN = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_write, resp_ready;
  logic [4:0]  req_addr;
  logic [31:0] req_wdata;
  logic        req_ready, resp_valid, resp_err;
  logic [31:0] resp_rdata;

  logic        req_valid0, req_write0, resp_ready0;
  logic [4:0]  req_addr0;
  logic [31:0] req_wdata0;
  logic        req_ready0, resp_valid0, resp_err0;
  logic [31:0] resp_rdata0;

  int n_checks = 0;
  int n_err    = 0;

  logic [7:0] mm [32];

  always #5 clk = ~clk;

  datmem_responder #(.WAIT(WAIT_MAIN)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  datmem_responder #(.WAIT(0)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid0), .req_ready(req_ready0), .req_write(req_write0),
    .req_addr(req_addr0), .req_wdata(req_wdata0),
    .resp_valid(resp_valid0), .resp_ready(resp_ready0),
    .resp_rdata(resp_rdata0), .resp_err(resp_err0)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One full transaction on the WAIT_MAIN instance; called at a negedge while idle
  task automatic do_req(input logic w, input logic [4:0] a, input logic [31:0] d, input int hold);
    logic [31:0] exp_d;
    logic        exp_e;
    logic [31:0] held;
    int          base;
    int          n;
    exp_e = (a[1:0] != 2'b00);
    exp_d = '0;
    base  = int'(a);
    if (!exp_e) begin
      if (w) begin
        mm[base]   = d[31:24];
        mm[base+1] = d[23:16];
        mm[base+2] = d[15:8];
        mm[base+3] = d[7:0];
      end else begin
        exp_d = {mm[base], mm[base+1], mm[base+2], mm[base+3]};
      end
    end
    chk("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
    @(negedge clk);
    req_valid = 1'b0;
    req_wdata = $urandom;
    n = 0;
    while (!resp_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("latency", 32'(n), 32'(WAIT_MAIN + 1));
    chk("resp_err", 32'(resp_err), 32'(exp_e));
    chk("resp_rdata", resp_rdata, exp_d);
    held = resp_rdata;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("bp_valid", 32'(resp_valid), 32'd1);
      chk("bp_rdata", resp_rdata, exp_d);
      chk("bp_req_ready", 32'(req_ready), 32'd0);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    chk("post_valid", 32'(resp_valid), 32'd0);
    chk("post_ready", 32'(req_ready), 32'd1);
    chk("post_rdata_kept", resp_rdata, held);
  endtask

  initial begin
    int k;
    logic [4:0] ra;
    rst_n = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; resp_ready = 1'b0;
    req_valid0 = 1'b0; req_write0 = 1'b1; req_addr0 = '0; req_wdata0 = 32'h0BAD_F00D; resp_ready0 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) do_req(1'b1, 5'(i * 4), $urandom, 0);

    // Basic write/read and byte ordering
    do_req(1'b1, 5'd8, 32'h1122_3344, 0);
    do_req(1'b0, 5'd8, 32'h0, 0);
    do_req(1'b1, 5'd12, 32'h0000_0000, 0);
    do_req(1'b0, 5'd8, 32'h0, 0);
    chk("model_b8", 32'(mm[8]), 32'h11);
    chk("model_b11", 32'(mm[11]), 32'h44);
    do_req(1'b0, 5'd12, 32'h0, 0);

    // Top of memory, address 0 untouched
    do_req(1'b1, 5'd28, 32'hAABB_CCDD, 0);
    do_req(1'b0, 5'd28, 32'h0, 0);
    do_req(1'b0, 5'd0, 32'h0, 0);

    // Misaligned store is rejected without touching memory
    do_req(1'b1, 5'd4, 32'hCAFE_F00D, 0);
    do_req(1'b1, 5'd6, 32'h1234_5678, 0);
    do_req(1'b0, 5'd4, 32'h0, 0);

    // Backpressure on a read of addr 8
    do_req(1'b0, 5'd8, 32'h0, 5);

    // Reset while the write is waiting with cnt=1
    req_valid = 1'b1; req_write = 1'b1; req_addr = 5'd8; req_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("arst_req_ready", 32'(req_ready), 32'd1);
    chk("arst_resp_valid", 32'(resp_valid), 32'd0);
    chk("arst_resp_rdata", resp_rdata, 32'd0);
    chk("arst_resp_err", 32'(resp_err), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_req_ready", 32'(req_ready), 32'd1);
    chk("rel_resp_valid", 32'(resp_valid), 32'd0);
    chk("rel_resp_rdata", resp_rdata, 32'd0);
    do_req(1'b0, 5'd8, 32'h0, 0);

    // Random traffic against the model
    for (int i = 0; i < 150; i++) begin
      ra = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 3) != 0) ra[1:0] = 2'b00;
      do_req(1'($urandom_range(0, 1)), ra, $urandom, int'($urandom_range(0, 3)));
    end

    // WAIT=0: held request and response-ready give one accept every 3 cycles
    req_valid0 = 1'b1;
    resp_ready0 = 1'b1;
    for (k = 0; k < 15; k++) begin
      @(negedge clk);
      chk("w0_resp_valid", 32'(resp_valid0), 32'((k % 3) == 1));
      chk("w0_req_ready", 32'(req_ready0), 32'((k % 3) == 2));
    end
    req_valid0 = 1'b0;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
